// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus: one owner drives for at most MAX_HOLD
// cycles, then the bus is released for TURNAROUND cycles before the next owner is chosen.
module tristate_bus_arbiter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NCH        = 4,
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned MAX_HOLD   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]       bus,
    output logic [NCH-1:0]         grant,
    output logic [$clog2(NCH)-1:0] owner,
    output logic                   bus_oe,
    output logic [WIDTH-1:0]       bus_hold,
    output logic                   busy
);

    localparam int unsigned OW = $clog2(NCH);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StTurn
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   w_owner_next;
    logic [7:0]      r_hold_cnt;
    logic [7:0]      w_hold_cnt_next;
    logic [3:0]      r_turn_cnt;
    logic [3:0]      w_turn_cnt_next;
    logic [WIDTH-1:0] r_bus_hold;

    logic            w_rr_found;
    logic [OW-1:0]   w_rr_idx;
    logic [WIDTH-1:0] w_drive_data;
    logic            w_drive;

    // Search starts just above the current owner so it is always considered last.
    always_comb begin
        int unsigned v_idx;
        logic [OW-1:0] v_sel;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        v_idx      = 0;
        v_sel      = '0;
        for (int k = 1; k <= int'(NCH); k++) begin
            v_idx = (int'(r_owner) + k) % NCH;
            v_sel = OW'(v_idx);
            if (!w_rr_found && req[v_sel]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = v_sel;
            end
        end
    end

    always_comb begin
        w_drive_data = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (r_owner == OW'(i)) begin
                w_drive_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_hold_cnt_next = r_hold_cnt;
        w_turn_cnt_next = r_turn_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_rr_found) begin
                    w_state_next    = StDrive;
                    w_owner_next    = w_rr_idx;
                    w_hold_cnt_next = '0;
                end
            end
            StDrive: begin
                if (!req[r_owner] || (r_hold_cnt == 8'(MAX_HOLD - 1))) begin
                    w_state_next    = StTurn;
                    w_turn_cnt_next = '0;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 8'd1;
                end
            end
            StTurn: begin
                if (r_turn_cnt == 4'(TURNAROUND - 1)) begin
                    if (w_rr_found) begin
                        w_state_next    = StDrive;
                        w_owner_next    = w_rr_idx;
                        w_hold_cnt_next = '0;
                    end else begin
                        w_state_next = StIdle;
                    end
                end else begin
                    w_turn_cnt_next = r_turn_cnt + 4'd1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_owner    <= OW'(NCH - 1);
            r_hold_cnt <= '0;
            r_turn_cnt <= '0;
            r_bus_hold <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_turn_cnt <= w_turn_cnt_next;
            if (r_state == StDrive) begin
                r_bus_hold <= w_drive_data;
            end
        end
    end

    // Outputs decode straight from registered state, so reset releases the bus at once.
    assign w_drive = (r_state == StDrive);

    always_comb begin
        grant = '0;
        if (w_drive) begin
            grant[r_owner] = 1'b1;
        end
    end

    assign bus      = w_drive ? w_drive_data : {WIDTH{1'bz}};
    assign bus_oe   = w_drive;
    assign owner    = r_owner;
    assign bus_hold = r_bus_hold;
    assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter (WIDTH=8, NCH=4, TURNAROUND=1, MAX_HOLD=4).
module tb_tristate_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [7:0]  bus;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        bus_oe;
    logic [7:0]  bus_hold;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    tristate_bus_arbiter #(
        .WIDTH(8),
        .NCH(4),
        .TURNAROUND(1),
        .MAX_HOLD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .data_in(data_in),
        .bus(bus),
        .grant(grant),
        .owner(owner),
        .bus_oe(bus_oe),
        .bus_hold(bus_hold),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_drive(input string tag, input int ch, input logic [7:0] val);
        logic [3:0] g;
        g = 4'b0001 << ch;
        chk({tag, " grant"}, 64'(grant), 64'(g));
        chk({tag, " owner"}, 64'(owner), 64'(ch));
        chk({tag, " bus_oe"}, 64'(bus_oe), 64'd1);
        chk({tag, " bus"}, 64'(bus), 64'(val));
        chk({tag, " busy"}, 64'(busy), 64'd1);
    endtask

    task automatic chk_released(input string tag, input logic exp_busy);
        chk({tag, " grant"}, 64'(grant), 64'd0);
        chk({tag, " bus_oe"}, 64'(bus_oe), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'(exp_busy));
    endtask

    // Continuous safety checks: never multi-hot, and oe tracks grant.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            assert ($onehot0(grant) && (bus_oe == (grant != 4'd0)))
            else begin
                n_fail++;
                $error("FAIL grant_onehot observed=%0h/%0b expected=onehot0/oe==|grant", grant,
                       bus_oe);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst grant", 64'(grant), 64'd0);
        chk("rst bus_oe", 64'(bus_oe), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst bus_hold", 64'(bus_hold), 64'd0);
        chk("rst owner", 64'(owner), 64'd3);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] chd [4];
        int         order [5];
        chd[0] = 8'h11; chd[1] = 8'h22; chd[2] = 8'h33; chd[3] = 8'h44;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

        rst = 1'b1;
        req = 4'b0000;
        data_in = '0;
        tick();
        tick();
        do_reset();

        // Single request, release, turnaround, idle
        data_in[7:0] = 8'hA5;
        req = 4'b0001;
        tick();
        chk_drive("a_drive", 0, 8'hA5);
        req = 4'b0000;
        tick();
        chk_released("a_turn", 1'b1);
        chk("a_turn hold", 64'(bus_hold), 64'hA5);
        tick();
        chk_released("a_idle", 1'b0);
        chk("a_idle hold", 64'(bus_hold), 64'hA5);

        // All channels requesting: rotate 0,1,2,3,0 with 4-cycle DRIVE and 1-cycle TURN
        tick();
        do_reset();
        for (int i = 0; i < 4; i++) data_in[i*8 +: 8] = chd[i];
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk_drive($sformatf("rr%0d_c%0d", n, c), order[n], chd[order[n]]);
            end
            tick();
            chk_released($sformatf("rr%0d_turn", n), 1'b1);
        end
        req = 4'b0000;
        tick();
        chk_released("rr_idle", 1'b0);

        // Lone requester is preempted but regranted after each TURN
        req = 4'b0100;
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk_drive($sformatf("solo%0d_c%0d", n, c), 2, 8'h33);
            end
            tick();
            chk_released($sformatf("solo%0d_turn", n), 1'b1);
        end
        tick();
        chk_drive("solo2_c0", 2, 8'h33);
        req = 4'b0000;
        tick();
        chk_released("solo_end_turn", 1'b1);
        tick();
        chk_released("solo_idle", 1'b0);

        // Reset mid-DRIVE releases the bus without a clock edge
        data_in[15:8] = 8'h3C;
        req = 4'b0010;
        tick();
        chk_drive("rstmid_c0", 1, 8'h3C);
        tick();
        chk_drive("rstmid_c1", 1, 8'h3C);
        chk("rstmid hold", 64'(bus_hold), 64'h3C);
        req = 4'b0000;
        do_reset();

        // Owner data follows combinationally; non-owner request is ignored mid-DRIVE
        data_in[31:24] = 8'h11;
        req = 4'b1000;
        tick();
        chk_drive("ch3_c0", 3, 8'h11);
        #2;
        data_in[31:24] = 8'h22;
        req = 4'b1001;
        #1;
        chk("ch3 bus follow", 64'(bus), 64'h22);
        chk("ch3 grant unchanged", 64'(grant), 64'b1000);
        tick();
        chk_drive("ch3_c1", 3, 8'h22);
        tick();
        chk_drive("ch3_c2", 3, 8'h22);
        req = 4'b0001;
        tick();
        chk_released("ch3_turn", 1'b1);
        chk("ch3 hold", 64'(bus_hold), 64'h22);
        tick();
        chk_drive("ch0_after", 0, 8'h11);
        req = 4'b0000;
        tick();
        tick();
        chk_released("final_idle", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
